aes_inv_cipher: RTL

Iterative AES inverse-cipher datapath that performs one decryption round per clock. It turns a 128-bit ciphertext block into plaintext using round keys fetched by index from an external round-key store; the key schedule is not part of this block. It is the decrypt-side counterpart of the encrypt round engine and instantiates 16 inv_s_box leaf modules (the FIPS-197 inverse S-box table, delivered as a separate combinational module). It uses valid/ready handshakes on the input and output block streams.

---
 rtl/aes_inv_cipher.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/aes_inv_cipher.sv
// Iterative AES inverse cipher: one decryption round per clock, with round keys
// fetched by index from an external key store. Also holds the inv_s_box leaf.

module inv_s_box (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  // FIPS-197 inverse S-box, entry 0x00 in the top byte
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  always_comb begin
    y_o = INV_SBOX[11'd2047 - {a_i, 3'd0} -: 8];
  end

endmodule

module aes_inv_cipher #(
  parameter int NR = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] data_i,
  output logic [3:0]   rk_idx_o,
  input  logic [127:0] rk_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] data_o
);

  if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
    $error("aes_inv_cipher: NR must be 10, 12 or 14");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] NR_W = 4'(NR);

  state_e       state_q, state_d;
  logic [127:0] blk_q, blk_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] shifted_s, sub_s, ark_s, mix_s;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Inverse MixColumns coefficients 9, b, d, e built from a shared x2/x4/x8 chain
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    logic [31:0] res;
    for (int j = 0; j < 4; j++) begin
      a[j]  = col[31-8*j -: 8];
      x2    = xtime(a[j]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[j] = x8 ^ a[j];
      mb[j] = x8 ^ x2 ^ a[j];
      md[j] = x8 ^ x4 ^ a[j];
      me[j] = x8 ^ x4 ^ x2;
    end
    for (int r = 0; r < 4; r++) begin
      res[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
    end
    return res;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] res;
    for (int c = 0; c < 4; c++) begin
      res[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end
    return res;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] res;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return res;
  endfunction

  always_comb begin
    shifted_s = inv_shift_rows(blk_q);
  end

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    inv_s_box u_inv_s_box (
      .a_i (shifted_s[127-8*i -: 8]),
      .y_o (sub_s[127-8*i -: 8])
    );
  end

  always_comb begin
    ark_s = sub_s ^ rk_i;
    mix_s = inv_mix_columns(ark_s);
  end

  // Outputs depend only on state and round counter, so rk_idx_o never loops back through rk_i
  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    round_d     = round_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    data_o      = '0;
    rk_idx_o    = NR_W;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          blk_d   = data_i ^ rk_i;
          round_d = NR_W - 4'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        rk_idx_o = round_q;
        blk_d    = mix_s;
        if (round_q == 4'd1) begin
          state_d = FINAL;
        end else begin
          round_d = round_q - 4'd1;
        end
      end
      FINAL: begin
        rk_idx_o = 4'd0;
        blk_d    = ark_s;
        round_d  = NR_W;
        state_d  = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        data_o      = blk_q;
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      blk_q   <= '0;
      round_q <= NR_W;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      round_q <= round_d;
    end
  end

endmodule
